// File: rtl/ft245_pkg.sv
// Shared types for the FT245 host-side emulator.
// Read/write strobe FSM states and the byte returned on an empty read.
package ft245_pkg;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ACTIVE,
        R_RECOVER
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_STROBE,
        W_RECOVER
    } wr_state_t;

    localparam logic [7:0] FT245_UDF_BYTE = 8'hFF;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO with AW+1-bit pointers.
// Push while full and pop while empty are ignored.
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wp;
    logic [AW:0]      r_rp;
    logic             w_push;
    logic             w_pop;

    // Extra MSB distinguishes full from empty when the indices match.
    assign o_empty = (r_wp == r_rp);
    assign o_full  = (r_wp[AW] != r_rp[AW]) &&
                     (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_rp[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + PTR_ONE;
            if (w_pop)  r_rp <= r_rp + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/ft245_host_emu.sv
// Host-side FT245BM emulator: byte streams in/out, FT245 pins to the engine.
// Define FT245_EMU_STATS_EN to build the saturating rx/tx byte counters.
module ft245_host_emu
    import ft245_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        nRXF,
    output logic        nTXE,
    input  logic        nRD,
    input  logic        WR,
    inout  wire  [7:0]  D,
    output logic        err_ovf,
    output logic        err_udf,
    output logic [15:0] rx_count,
    output logic [15:0] tx_count
);

    rd_state_t  r_rd_st;
    rd_state_t  w_rd_nx;
    wr_state_t  r_wr_st;
    wr_state_t  w_wr_nx;

    logic       r_nrd_q;
    logic       r_wr_q;
    logic       r_udf_xfer;
    logic       r_err_ovf;
    logic       r_err_udf;

    logic       w_rx_push;
    logic       w_rx_pop;
    logic       w_rx_full;
    logic       w_rx_empty;
    logic [7:0] w_rx_head;
    logic       w_tx_push;
    logic       w_tx_pop;
    logic       w_tx_full;
    logic       w_tx_empty;
    logic [7:0] w_tx_head;

    logic       w_rd_rise;
    logic       w_wr_fall;
    logic       w_capture;
    logic       w_udf_set;
    logic       w_ovf_set;
    logic       w_drive;

    assign w_rd_rise = nRD && !r_nrd_q;
    assign w_wr_fall = !WR && r_wr_q;

    always_comb begin
        w_rd_nx   = r_rd_st;
        w_rx_pop  = 1'b0;
        w_udf_set = 1'b0;
        unique case (r_rd_st)
            R_IDLE: begin
                if (!nRD) begin
                    w_rd_nx   = R_ACTIVE;
                    w_udf_set = w_rx_empty;
                end
            end
            R_ACTIVE: begin
                if (w_rd_rise) begin
                    w_rd_nx  = R_RECOVER;
                    w_rx_pop = !r_udf_xfer && !w_rx_empty;
                end
            end
            R_RECOVER: w_rd_nx = R_IDLE;
            default:   w_rd_nx = R_IDLE;
        endcase
    end

    always_comb begin
        w_wr_nx   = r_wr_st;
        w_capture = 1'b0;
        unique case (r_wr_st)
            W_IDLE: begin
                if (WR) w_wr_nx = W_STROBE;
            end
            W_STROBE: begin
                if (w_wr_fall) begin
                    w_wr_nx   = W_RECOVER;
                    w_capture = 1'b1;
                end
            end
            W_RECOVER: w_wr_nx = W_IDLE;
            default:   w_wr_nx = W_IDLE;
        endcase
    end

    // Engine keeps D valid the cycle after WR falls, so capture then.
    assign w_tx_push = w_capture && !w_tx_full;
    assign w_ovf_set = w_capture && w_tx_full;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rd_st    <= R_IDLE;
            r_wr_st    <= W_IDLE;
            r_nrd_q    <= 1'b1;
            r_wr_q     <= 1'b0;
            r_udf_xfer <= 1'b0;
            r_err_ovf  <= 1'b0;
            r_err_udf  <= 1'b0;
        end else begin
            r_rd_st <= w_rd_nx;
            r_wr_st <= w_wr_nx;
            r_nrd_q <= nRD;
            r_wr_q  <= WR;
            if (r_rd_st == R_IDLE) r_udf_xfer <= w_udf_set;
            if (w_udf_set) r_err_udf <= 1'b1;
            if (w_ovf_set) r_err_ovf <= 1'b1;
        end
    end

    assign w_rx_push = s_valid && s_ready;
    assign w_tx_pop  = m_valid && m_ready;

    sync_fifo_fwft #(.WIDTH(8), .DEPTH(DEPTH)) u_rx (
        .clk     (CLK),
        .rst     (RST),
        .i_push  (w_rx_push),
        .i_din   (s_data),
        .i_pop   (w_rx_pop),
        .o_head  (w_rx_head),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty)
    );

    sync_fifo_fwft #(.WIDTH(8), .DEPTH(DEPTH)) u_tx (
        .clk     (CLK),
        .rst     (RST),
        .i_push  (w_tx_push),
        .i_din   (D),
        .i_pop   (w_tx_pop),
        .o_head  (w_tx_head),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty)
    );

    assign w_drive = (r_rd_st == R_ACTIVE) && !nRD && !WR;
    assign D       = w_drive ? (r_udf_xfer ? FT245_UDF_BYTE : w_rx_head)
                             : 8'hzz;

    assign nRXF    = RST || (r_rd_st != R_IDLE) || w_rx_empty;
    assign nTXE    = RST || (r_wr_st != W_IDLE) || w_tx_full;
    assign s_ready = !RST && !w_rx_full;
    assign m_valid = !w_tx_empty;
    assign m_data  = w_tx_head;
    assign err_ovf = r_err_ovf;
    assign err_udf = r_err_udf;

`ifdef FT245_EMU_STATS_EN
    logic [15:0] r_rx_cnt;
    logic [15:0] r_tx_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rx_cnt <= '0;
            r_tx_cnt <= '0;
        end else begin
            if (w_rx_pop && r_rx_cnt != 16'hFFFF) r_rx_cnt <= r_rx_cnt + 16'd1;
            if (w_tx_push && r_tx_cnt != 16'hFFFF) r_tx_cnt <= r_tx_cnt + 16'd1;
        end
    end

    assign rx_count = r_rx_cnt;
    assign tx_count = r_tx_cnt;
`else
    assign rx_count = '0;
    assign tx_count = '0;
`endif

endmodule

// File: tb/tb_ft245_host_emu.sv
// Self-checking bench for ft245_host_emu: directed scenarios plus random
// traffic compared against queue-based models of both FIFOs.
module tb_ft245_host_emu;

    localparam int DEPTH = 16;
`ifdef FT245_EMU_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        nRXF;
    logic        nTXE;
    logic        nRD;
    logic        WR;
    wire  [7:0]  D;
    logic        err_ovf;
    logic        err_udf;
    logic [15:0] rx_count;
    logic [15:0] tx_count;

    logic        tb_drv;
    logic [7:0]  tb_d;

    assign D = tb_drv ? tb_d : 8'hzz;

    always #5 CLK = ~CLK;

    ft245_host_emu #(.DEPTH(DEPTH)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .nRXF     (nRXF),
        .nTXE     (nTXE),
        .nRD      (nRD),
        .WR       (WR),
        .D        (D),
        .err_ovf  (err_ovf),
        .err_udf  (err_udf),
        .rx_count (rx_count),
        .tx_count (tx_count)
    );

    int total = 0;
    int bad   = 0;

    byte unsigned rxq[$];
    byte unsigned txq[$];
    bit           m_ovf;
    bit           m_udf;
    int           m_rxc;
    int           m_txc;

    task automatic check(string tag, logic [15:0] got, logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] cnt_exp(int c);
        if (!STATS) return 16'h0;
        return (c > 65535) ? 16'hFFFF : 16'(c);
    endfunction

    task automatic model_reset();
        rxq.delete();
        txq.delete();
        m_ovf = 0;
        m_udf = 0;
        m_rxc = 0;
        m_txc = 0;
    endtask

    // Called with both strobe FSMs idle.
    task automatic check_flags(string tag);
        check({tag, ":s_ready"}, 16'(s_ready), 16'(rxq.size() < DEPTH));
        check({tag, ":nRXF"}, 16'(nRXF), 16'(rxq.size() == 0));
        check({tag, ":m_valid"}, 16'(m_valid), 16'(txq.size() != 0));
        check({tag, ":nTXE"}, 16'(nTXE), 16'(txq.size() == DEPTH));
        check({tag, ":err_ovf"}, 16'(err_ovf), 16'(m_ovf));
        check({tag, ":err_udf"}, 16'(err_udf), 16'(m_udf));
        check({tag, ":rx_count"}, rx_count, cnt_exp(m_rxc));
        check({tag, ":tx_count"}, tx_count, cnt_exp(m_txc));
        if (txq.size() != 0)
            check({tag, ":m_data"}, 16'(m_data), 16'(txq[0]));
    endtask

    task automatic s_push(input byte unsigned b);
        @(negedge CLK);
        s_data  = b;
        s_valid = 1'b1;
        check("push_ready", 16'(s_ready), 16'd1);
        @(negedge CLK);
        s_valid = 1'b0;
        rxq.push_back(b);
    endtask

    task automatic eng_read(input bit frc);
        int          n;
        logic [7:0]  got;
        byte unsigned exp;
        n = 0;
        @(negedge CLK);
        if (!frc) begin
            while (nRXF && n < 50) begin
                @(negedge CLK);
                n++;
            end
            if (nRXF) begin
                check("rd_timeout_nrxf", 16'(nRXF), 16'd0);
                return;
            end
        end
        nRD = 1'b0;
        @(negedge CLK);
        got = D;
        nRD = 1'b1;
        if (rxq.size() == 0) begin
            exp   = 8'hFF;
            m_udf = 1'b1;
        end else begin
            exp = rxq.pop_front();
            m_rxc++;
        end
        check("rd_data", 16'(got), 16'(exp));
        @(negedge CLK);
        check("rd_recover_nrxf", 16'(nRXF), 16'd1);
        @(negedge CLK);
    endtask

    task automatic eng_write(input byte unsigned b);
        bit was_empty;
        was_empty = (txq.size() == 0);
        @(negedge CLK);
        tb_d   = b;
        tb_drv = 1'b1;
        WR     = 1'b1;
        @(negedge CLK);
        WR = 1'b0;
        @(negedge CLK);
        tb_drv = 1'b0;
        if (txq.size() < DEPTH) begin
            txq.push_back(b);
            m_txc++;
        end else begin
            m_ovf = 1'b1;
        end
        if (was_empty)
            check("cap_to_mvalid", 16'(m_valid), 16'd1);
        @(negedge CLK);
    endtask

    task automatic m_pop();
        @(negedge CLK);
        check("pop_valid", 16'(m_valid), 16'd1);
        check("pop_data", 16'(m_data), 16'(txq[0]));
        m_ready = 1'b1;
        @(negedge CLK);
        m_ready = 1'b0;
        void'(txq.pop_front());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        RST     = 1'b1;
        s_data  = '0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        nRD     = 1'b1;
        WR      = 1'b0;
        tb_drv  = 1'b0;
        tb_d    = '0;
        model_reset();
        repeat (3) @(negedge CLK);
        check("rst_nRXF", 16'(nRXF), 16'd1);
        check("rst_nTXE", 16'(nTXE), 16'd1);
        check("rst_s_ready", 16'(s_ready), 16'd0);
        check("rst_m_valid", 16'(m_valid), 16'd0);
        check("rst_err_ovf", 16'(err_ovf), 16'd0);
        check("rst_err_udf", 16'(err_udf), 16'd0);
        check("rst_rx_count", rx_count, 16'd0);
        check("rst_tx_count", tx_count, 16'd0);
        RST = 1'b0;
        @(negedge CLK);
        check_flags("post_reset");

        s_push(8'h2A);
        check("nrxf_latency", 16'(nRXF), 16'd0);
        eng_read(1'b0);
        check_flags("single_read");

        s_push(8'hC1);
        s_push(8'h55);
        eng_read(1'b0);
        eng_read(1'b0);
        eng_write(8'h55);
        check_flags("loopback");
        m_pop();
        check_flags("loopback_drain");

        for (int i = 0; i < DEPTH; i++) s_push(8'(i + 8'h30));
        check_flags("rx_full");
        eng_read(1'b0);
        check("rx_ready_after_read", 16'(s_ready), 16'd1);
        while (rxq.size() != 0) eng_read(1'b0);
        check_flags("rx_drained");

        for (int i = 0; i < 40; i++) begin
            if (rxq.size() == DEPTH) eng_read(1'b0);
            s_push(8'(i));
            if (i % 3 == 2) eng_read(1'b0);
        end
        while (rxq.size() != 0) eng_read(1'b0);
        check_flags("rx_wrap");

        for (int i = 0; i < DEPTH; i++) eng_write(8'(8'hA0 + i));
        check_flags("tx_full");
        eng_write(8'hEE);
        check_flags("tx_overflow");
        for (int i = 0; i < DEPTH; i++) m_pop();
        check_flags("tx_drained");

        eng_read(1'b1);
        check_flags("underflow");
        s_push(8'h77);
        eng_read(1'b0);
        check_flags("after_underflow");

        eng_write(8'h11);
        for (int i = 0; i < 3; i++) s_push(8'(8'hB0 + i));
        @(negedge CLK);
        nRD = 1'b0;
        @(negedge CLK);
        check("active_d", 16'(D), 16'(rxq[0]));
        RST    = 1'b1;
        nRD    = 1'b1;
        tb_drv = 1'b1;
        tb_d   = 8'h3C;
        @(negedge CLK);
        check("midrst_nRXF", 16'(nRXF), 16'd1);
        check("midrst_nTXE", 16'(nTXE), 16'd1);
        check("midrst_s_ready", 16'(s_ready), 16'd0);
        check("midrst_m_valid", 16'(m_valid), 16'd0);
        check("midrst_err_ovf", 16'(err_ovf), 16'd0);
        check("midrst_err_udf", 16'(err_udf), 16'd0);
        check("midrst_d_released", 16'(D), 16'h3C);
        tb_drv = 1'b0;
        RST    = 1'b0;
        model_reset();
        @(negedge CLK);
        check_flags("after_midrst");

        for (int i = 0; i < 5; i++) begin
            s_push(8'(8'h60 + i));
            eng_read(1'b0);
        end
        for (int i = 0; i < 3; i++) eng_write(8'(8'h70 + i));
        check_flags("stats");
        for (int i = 0; i < 3; i++) m_pop();

        repeat (300) begin
            case ($urandom_range(0, 4))
                0, 1: if (rxq.size() < DEPTH) s_push(8'($urandom));
                2:    if (rxq.size() != 0) eng_read(1'b0);
                3:    eng_write(8'($urandom));
                default: if (txq.size() != 0) m_pop();
            endcase
            check_flags("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
